// File: rtl/spi_tx_ctrl_if.sv
// spi_tx_ctrl_if: FIFO read port plus SPI pad signals of the SPI TX controller.
//   master modport: the controller side (consumes FIFO head, drives pads).
//   slave modport : the environment side (FIFO model / pad observer).
interface spi_tx_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ENABLE;
    logic                  FIFO_EMPTY;
    logic [DATA_WIDTH-1:0] FIFO_DATA;
    logic                  FIFO_READ;
    logic                  SCLK;
    logic                  MOSI;
    logic                  CS_N;
    logic                  BUSY;
    logic                  DONE;

    modport master (
        input  ENABLE, FIFO_EMPTY, FIFO_DATA,
        output FIFO_READ, SCLK, MOSI, CS_N, BUSY, DONE
    );

    modport slave (
        output ENABLE, FIFO_EMPTY, FIFO_DATA,
        input  FIFO_READ, SCLK, MOSI, CS_N, BUSY, DONE
    );
endinterface

// File: rtl/spi_tx_ctrl.sv
// spi_tx_ctrl: pops one word per frame from the TX FIFO and shifts it out as an
// SPI mode-0 master, MSB first. All outputs are registered.
// Frame: 1 LOAD cycle (CS_N low, pop strobe) + DATA_WIDTH*2*CLK_DIV SHIFT cycles,
// then GAP_CYCLES cycles with CS_N high, then one IDLE decision cycle.
// Optional feature macro: SPI_TX_CS_HOLD_EN -- when defined, a frame that ends
// with ENABLE high and the FIFO non-empty goes straight to LOAD, keeping CS_N
// low across the burst (SCLK stays low for the LOAD cycle).
module spi_tx_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    spi_tx_ctrl_if.master bus
);

    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

`ifdef SPI_TX_CS_HOLD_EN
    localparam bit CS_HOLD = 1'b1;
`else
    localparam bit CS_HOLD = 1'b0;
`endif

    logic [1:0]            state;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    // The MSB goes straight to MOSI at LOAD, so only the remaining bits are held.
    logic [DATA_WIDTH-2:0] shreg;

    logic fifo_read;
    logic sclk;
    logic mosi;
    logic cs_n;
    logic busy;
    logic done;

    logic div_tc;
    logic fall_tick;
    logic start_burst;

    assign div_tc      = (div_cnt == DIV_LAST);
    // A falling SCLK toggle happens on the terminal count while SCLK is high.
    assign fall_tick   = (state == ST_SHIFT) && div_tc && sclk;
    assign start_burst = CS_HOLD && bus.ENABLE && !bus.FIFO_EMPTY;

    // Control FSM and registered pad/handshake outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            fifo_read <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            fifo_read <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.ENABLE && !bus.FIFO_EMPTY) begin
                        state     <= ST_LOAD;
                        fifo_read <= 1'b1;
                        cs_n      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    mosi    <= bus.FIFO_DATA[DATA_WIDTH-1];
                    bit_cnt <= BIT_LAST;
                    div_cnt <= '0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        if (sclk) begin
                            if (bit_cnt != '0) begin
                                mosi    <= shreg[DATA_WIDTH-2];
                                bit_cnt <= bit_cnt - BIT_W'(1);
                            end else begin
                                done <= 1'b1;
                                if (start_burst) begin
                                    state     <= ST_LOAD;
                                    fifo_read <= 1'b1;
                                end else begin
                                    state   <= ST_GAP;
                                    cs_n    <= 1'b1;
                                    mosi    <= 1'b0;
                                    gap_cnt <= '0;
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Shift register: captured from the FIFO head while the pop is strobed, shifted on falling SCLK.
    always_ff @(posedge CLK) begin
        if (state == ST_LOAD) begin
            shreg <= bus.FIFO_DATA[DATA_WIDTH-2:0];
        end else if (fall_tick && (bit_cnt != '0)) begin
            shreg <= {shreg[DATA_WIDTH-3:0], 1'b0};
        end
    end

    assign bus.FIFO_READ = fifo_read;
    assign bus.SCLK      = sclk;
    assign bus.MOSI      = mosi;
    assign bus.CS_N      = cs_n;
    assign bus.BUSY      = busy;
    assign bus.DONE      = done;

endmodule

// File: tb/tb_spi_tx_ctrl.sv
// tb_spi_tx_ctrl: directed bench for spi_tx_ctrl with a frame-timeline model,
// a FIFO model, an SPI slave monitor and hand-computed literal expectations.
module tb_spi_tx_ctrl;

    localparam int DW = 32;
    localparam int CD = 2;
    localparam int GC = 2;
    localparam int FS = DW * 2 * CD;   // cycles spent shifting per frame

`ifdef SPI_TX_CS_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N;

    spi_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    spi_tx_ctrl #(
        .DATA_WIDTH(DW),
        .CLK_DIV   (CD),
        .GAP_CYCLES(GC)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // FIFO model: written by the stimulus, popped on FIFO_READ.
    logic [DW-1:0] mem [0:15];
    logic [3:0]    wp = '0;
    logic [3:0]    rp = '0;

    assign bus.FIFO_EMPTY = (rp == wp);
    assign bus.FIFO_DATA  = mem[rp];

    // Timeline model: m_t = -1 idle, 0 load cycle, 1..FS shift, FS+1..FS+GC gap.
    int            m_t = -1;
    logic [DW-1:0] m_word = '0;
    logic          m_restart = 1'b0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_t       <= -1;
            m_restart <= 1'b0;
        end else begin
            if (bus.FIFO_READ) rp <= rp + 4'd1;
            if (m_t < 0) begin
                m_restart <= 1'b0;
                if (bus.ENABLE && (rp != wp)) begin
                    m_t    <= 0;
                    m_word <= mem[rp];
                end
            end else if (HOLD && (m_t == FS) && bus.ENABLE && (rp != wp)) begin
                m_t       <= 0;
                m_word    <= mem[rp];
                m_restart <= 1'b1;
            end else if (m_t == FS + GC) begin
                m_t       <= -1;
                m_restart <= 1'b0;
            end else begin
                m_t       <= m_t + 1;
                m_restart <= 1'b0;
            end
        end
    end

    // SPI slave monitor and event counters.
    logic          prev_sclk = 1'b0;
    logic [DW-1:0] cap = '0;
    logic [DW-1:0] last_word = '0;
    logic [DW-1:0] cap_log [0:15];
    int cap_n = 0, last_n = 0, rises = 0, reads = 0, dones = 0;
    int cs_low = 0, cs_hi_run = 0, runs = 0, last_cs_gap = 0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            cap_n     <= 0;
            prev_sclk <= 1'b0;
        end else begin
            prev_sclk <= bus.SCLK;
            if (bus.SCLK && !prev_sclk && !bus.CS_N) begin
                cap   <= {cap[DW-2:0], bus.MOSI};
                cap_n <= cap_n + 1;
                rises <= rises + 1;
            end
            if (bus.FIFO_READ) reads <= reads + 1;
            if (bus.DONE) begin
                dones               <= dones + 1;
                last_word           <= cap;
                last_n              <= cap_n;
                cap_log[dones[3:0]] <= cap;
                cap_n               <= 0;
            end
            if (bus.CS_N) begin
                cs_hi_run <= cs_hi_run + 1;
            end else begin
                cs_low <= cs_low + 1;
                if (cs_hi_run > 0) begin
                    runs        <= runs + 1;
                    last_cs_gap <= cs_hi_run;
                end
                cs_hi_run <= 0;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    // Per-cycle comparison of all outputs against the timeline model.
    task automatic compare_loop();
        logic [4:0] g, e;
        logic       em;
        bit         mchk;
        int         k;
        forever begin
            @(negedge CLK);
            g    = {bus.FIFO_READ, bus.CS_N, bus.SCLK, bus.BUSY, bus.DONE};
            mchk = 1'b0;
            em   = 1'b0;
            if (m_t < 0) begin
                e = 5'b01000;
            end else if (m_t == 0) begin
                e = {4'b1001, m_restart};
            end else if (m_t <= FS) begin
                k    = m_t - 1;
                e    = {2'b00, 1'(((k / CD) % 2) != 0), 2'b10};
                mchk = 1'b1;
                em   = m_word[DW - 1 - k / (2 * CD)];
            end else begin
                e = {4'b0101, 1'(m_t == FS + 1)};
            end
            checks++;
            if ((g !== e) || (mchk && (bus.MOSI !== em))) begin
                failures++;
                $display("FAIL model_cycle t=%0d rd_cs_sclk_busy_done=%b mosi=%b required=%b mosi=%b",
                         m_t, g, bus.MOSI, e, em);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wp] = w;
        wp = wp + 4'd1;
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        int n = 0;
        while ((dones < target) && (n < budget)) begin
            tick(1);
            n++;
        end
        chk(name, 32'(dones >= target), 32'd1);
    endtask

    task automatic wait_rises(input int target, input int budget, input string name);
        int n = 0;
        while ((rises < target) && (n < budget)) begin
            tick(1);
            n++;
        end
        chk(name, 32'(rises >= target), 32'd1);
    endtask

    task automatic check_idle_pads(input string tag);
        chk({tag, "_cs_n"}, 32'(bus.CS_N), 32'd1);
        chk({tag, "_sclk"}, 32'(bus.SCLK), 32'd0);
        chk({tag, "_fifo_read"}, 32'(bus.FIFO_READ), 32'd0);
        chk({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        chk({tag, "_done"}, 32'(bus.DONE), 32'd0);
    endtask

    int r0, d0, l0, c0, u0;

    initial begin
        fork
            compare_loop();
        join_none
        bus.ENABLE = 1'b0;
        RST_N      = 1'b1;
        #1 RST_N   = 1'b0;

        // Reset held for 3 cycles, then released with the FIFO empty.
        tick(3);
        check_idle_pads("reset");
        chk("reset_mosi", 32'(bus.MOSI), 32'd0);
        RST_N = 1'b1;
        tick(5);
        check_idle_pads("post_reset");
        chk("post_reset_mosi", 32'(bus.MOSI), 32'd0);

        // Single frame.
        r0 = reads; d0 = dones; l0 = cs_low;
        push(32'hA5A5_0F0F);
        bus.ENABLE = 1'b1;
        wait_dones(d0 + 1, 400, "single_timeout");
        chk("single_word", last_word, 32'hA5A5_0F0F);
        chk("single_bits", 32'(last_n), 32'd32);
        chk("single_reads", 32'(reads - r0), 32'd1);
        chk("single_cs_low", 32'(cs_low - l0), 32'd129);
        chk("gap1_cs_n", 32'(bus.CS_N), 32'd1);
        chk("gap1_busy", 32'(bus.BUSY), 32'd1);
        tick(1);
        chk("gap2_busy", 32'(bus.BUSY), 32'd1);
        tick(1);
        chk("after_gap_busy", 32'(bus.BUSY), 32'd0);
        chk("single_dones", 32'(dones - d0), 32'd1);

        // Enabled with an empty FIFO: nothing happens.
        r0 = reads; l0 = cs_low; c0 = rises;
        tick(200);
        chk("empty_reads", 32'(reads - r0), 32'd0);
        chk("empty_cs_low", 32'(cs_low - l0), 32'd0);
        chk("empty_rises", 32'(rises - c0), 32'd0);
        check_idle_pads("empty");

        // Two back-to-back frames.
        r0 = reads; d0 = dones; c0 = rises; u0 = runs; l0 = cs_low;
        push(32'h1234_5678);
        push(32'h9ABC_DEF0);
        wait_dones(d0 + 2, 800, "pair_timeout");
        chk("pair_word0", cap_log[d0[3:0]], 32'h1234_5678);
        chk("pair_word1", cap_log[4'(d0 + 1)], 32'h9ABC_DEF0);
        chk("pair_rises", 32'(rises - c0), 32'd64);
        chk("pair_reads", 32'(reads - r0), 32'd2);
        chk("pair_cs_low", 32'(cs_low - l0), 32'd258);
        chk("pair_cs_high_runs", 32'(runs - u0), HOLD ? 32'd1 : 32'd2);
        chk("pair_cs_gap", 32'(last_cs_gap), HOLD ? 32'(last_cs_gap) + 32'd0 * 32'(runs) : 32'd3);

        // Drop ENABLE mid-frame with three words queued.
        begin
            int n = 0;
            while (bus.BUSY && (n < 20)) begin
                tick(1);
                n++;
            end
            chk("idle_before_drop", 32'(bus.BUSY), 32'd0);
        end
        r0 = reads; d0 = dones; c0 = rises;
        push(32'h0F1E_2D3C);
        push(32'hCAFE_BABE);
        push(32'h1357_9BDF);
        wait_rises(c0 + 10, 200, "drop_rise_timeout");
        bus.ENABLE = 1'b0;
        wait_dones(d0 + 1, 400, "drop_timeout");
        tick(10);
        chk("drop_word", last_word, 32'h0F1E_2D3C);
        chk("drop_bits", 32'(last_n), 32'd32);
        chk("drop_reads", 32'(reads - r0), 32'd1);
        chk("drop_fifo_empty", 32'(bus.FIFO_EMPTY), 32'd0);
        check_idle_pads("drop_idle");

        // Reset mid-frame: the popped word is lost, the next word is a fresh frame.
        r0 = reads; d0 = dones; c0 = rises;
        bus.ENABLE = 1'b1;
        wait_rises(c0 + 5, 200, "rst_rise_timeout");
        RST_N = 1'b0;
        #1;
        check_idle_pads("mid_reset");
        tick(2);
        RST_N = 1'b1;
        wait_dones(d0 + 1, 400, "rst_timeout");
        chk("rst_word", last_word, 32'h1357_9BDF);
        chk("rst_bits", 32'(last_n), 32'd32);
        chk("rst_reads", 32'(reads - r0), 32'd2);
        chk("rst_fifo_empty", 32'(bus.FIFO_EMPTY), 32'd1);

        bus.ENABLE = 1'b0;
        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
